// File: rtl/apb_req_queue.sv
// ============================================================================
// apb_req_queue
// ----------------------------------------------------------------------------
// Request buffer / sequencer sitting directly upstream of the APB bridge
// wrapper. Commands arrive on a valid/ready port and are held in a
// DEPTH-entry FIFO. The head command is presented to the bridge one at a time
// on registered SWRITE/SADDR/SWDATA/SSTRB/SPROT with 'transfer' high for the
// whole access. Each command produces exactly one response pulse, carrying
// PRDATA for reads.
//
// Optional feature (compile-time macro APB_REQ_TIMEOUT_EN):
//   defined   : a BUSY-cycle counter aborts a command after TIMEOUT_CYCLES
//               cycles without xfer_done and reports it with rsp_err=1.
//   undefined : no counter, rsp_err is tied low, BUSY waits for xfer_done.
//
// Ports
//   PCLK, PRESETn          clock (rising edge) / async active-low reset
//   req_valid, req_ready   command handshake (ready = FIFO not full)
//   req_write/addr/wdata/strb/prot   command fields
//   SWRITE/SADDR/SWDATA/SSTRB/SPROT  registered command to the bridge
//   transfer               high throughout an access to the bridge
//   PRDATA, xfer_done      read data / access-complete from the bridge
//   rsp_valid              one-cycle pulse per completed command
//   rsp_write, rsp_rdata, rsp_err    response fields, held until next response
// ============================================================================

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_req_queue #(
    parameter int ADDR_W         = `APB_ADDR_WIDTH,
    parameter int DATA_W         = `APB_DATA_WIDTH,
    parameter int STRB_W         = `APB_STRB_WIDTH,
    parameter int PROT_W         = `APB_PROT_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [PROT_W-1:0] req_prot,
    output logic              SWRITE,
    output logic [ADDR_W-1:0] SADDR,
    output logic [DATA_W-1:0] SWDATA,
    output logic [STRB_W-1:0] SSTRB,
    output logic [PROT_W-1:0] SPROT,
    output logic              transfer,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              xfer_done,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W + PROT_W;

    // Pointers wrap by natural overflow, which is why DEPTH must be a power of 2.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_req_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               tmo_hit;

    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [STRB_W-1:0]  head_strb;
    logic [PROT_W-1:0]  head_prot;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in a cycle where the head is being popped.
    assign req_ready = (count != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == BUSY) && (xfer_done || tmo_hit);

    assign {head_write, head_addr, head_wdata, head_strb, head_prot} = fifo_mem[rd_ptr];

    // Storage array: contents need no reset because count gates every read.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata, req_strb, req_prot};
        end
    end

    // Pointer and occupancy bookkeeping. The head entry stays counted while it
    // is in flight and only leaves the FIFO when its access completes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: IDLE latches the head into the bridge registers, BUSY holds
    // them until the access ends. Returning to IDLE for a cycle guarantees a
    // transfer-low gap between consecutive commands.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            SWRITE    <= 1'b0;
            SADDR     <= '0;
            SWDATA    <= '0;
            SSTRB     <= '0;
            SPROT     <= '0;
            transfer  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        SWRITE   <= head_write;
                        SADDR    <= head_addr;
                        SWDATA   <= head_wdata;
                        SSTRB    <= head_strb;
                        SPROT    <= head_prot;
                        transfer <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (pop) begin
                        transfer  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= SWRITE;
                        // Writes and aborted commands return zero data.
                        rsp_rdata <= (SWRITE || tmo_hit) ? '0 : PRDATA;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APB_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rsp_err_q;

    // xfer_done wins over an expiring timeout in the same cycle.
    assign tmo_hit = (state == BUSY) && !xfer_done
                     && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = rsp_err_q;

    // Counter sits at zero in IDLE so every BUSY entry starts a fresh count;
    // the error flag is rewritten with each response and held in between.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == IDLE || pop) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (pop) begin
                rsp_err_q <= tmo_hit;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
